// File: rtl/line_trig_sequencer_pkg.sv
// rtl/line_trig_sequencer_pkg.sv - shared types and default sizing for the line trigger sequencer
// Package line_trig_pkg: frame FSM state encoding and default CNT_W / PULSE_W / MIN_GAP.
package line_trig_pkg;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_PULSE_W = 8;
  localparam int DEF_MIN_GAP = 64;

  // Encoding is visible on state_o, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/line_trig_sequencer_if.sv
// rtl/line_trig_sequencer_if.sv - control/config/status bundle of the line trigger sequencer
// Inputs (master drives): enable, arm, trig_toggle_in, dir_in, cfg_start_delay, cfg_lines,
//   cfg_continuous.
// Outputs (slave drives): line_trig_out, frame_active, frame_done, line_count, overrun_cnt, state_o.
interface line_trig_sequencer_if #(
  parameter int CNT_W = 16
) ();

  logic             enable;
  logic             arm;
  logic             trig_toggle_in;
  logic             dir_in;
  logic [CNT_W-1:0] cfg_start_delay;
  logic [CNT_W-1:0] cfg_lines;
  logic             cfg_continuous;

  logic             line_trig_out;
  logic             frame_active;
  logic             frame_done;
  logic [CNT_W-1:0] line_count;
  logic [7:0]       overrun_cnt;
  logic [1:0]       state_o;

  modport master (
    output enable, arm, trig_toggle_in, dir_in, cfg_start_delay, cfg_lines, cfg_continuous,
    input  line_trig_out, frame_active, frame_done, line_count, overrun_cnt, state_o
  );

  modport slave (
    input  enable, arm, trig_toggle_in, dir_in, cfg_start_delay, cfg_lines, cfg_continuous,
    output line_trig_out, frame_active, frame_done, line_count, overrun_cnt, state_o
  );

endinterface

// File: rtl/line_trig_sequencer_pulse_gen.sv
// rtl/line_trig_sequencer_pulse_gen.sv - fixed-width pulse generator with minimum rising-edge spacing
// Module line_trig_pulse_gen.
// Ports: clk, rst (async, active high); req_i (qualified event asking for a line);
//   accept_o / drop_o (decision for req_i this cycle); rise_o (pulse_o rises on the next edge);
//   pulse_o (the line trigger); busy_o (pulse pending or high).
module line_trig_pulse_gen #(
  parameter int PULSE_W = 8,
  parameter int MIN_GAP = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  output logic accept_o,
  output logic drop_o,
  output logic rise_o,
  output logic pulse_o,
  output logic busy_o
);

  localparam int GAP_W = $clog2(MIN_GAP + 1);
  localparam int PW_W  = $clog2(PULSE_W + 1);

  logic             start_q, start_d;
  logic             pulse_q, pulse_d;
  logic [PW_W-1:0]  wcnt_q, wcnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             gap_ok;

  // gap_q counts edges since the accepting edge, which precedes the rise by exactly one
  // cycle, so MIN_GAP-1 here means MIN_GAP cycles between the two rising edges. Since
  // MIN_GAP > PULSE_W this also guarantees the previous pulse has ended before the next rises.
  assign gap_ok   = (gap_q >= GAP_W'(MIN_GAP - 1));
  assign accept_o = req_i && gap_ok && !start_q;
  assign drop_o   = req_i && !accept_o;
  assign rise_o   = start_q;
  assign pulse_o  = pulse_q;
  assign busy_o   = start_q || pulse_q;

  always_comb begin
    start_d = accept_o;
    pulse_d = pulse_q;
    wcnt_d  = wcnt_q;
    gap_d   = gap_q;
    if (accept_o) begin
      gap_d = '0;
    end else if (gap_q != GAP_W'(MIN_GAP)) begin
      gap_d = gap_q + GAP_W'(1);
    end
    // wcnt holds the remaining high cycles after the current one.
    if (start_q) begin
      pulse_d = 1'b1;
      wcnt_d  = PW_W'(PULSE_W - 1);
    end else if (pulse_q) begin
      if (wcnt_q == '0) begin
        pulse_d = 1'b0;
      end else begin
        wcnt_d = wcnt_q - PW_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      pulse_q <= 1'b0;
      wcnt_q  <= '0;
      gap_q   <= GAP_W'(MIN_GAP);
    end else begin
      start_q <= start_d;
      pulse_q <= pulse_d;
      wcnt_q  <= wcnt_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: rtl/line_trig_sequencer.sv
// rtl/line_trig_sequencer.sv - frame/line trigger scheduler turning encoder toggles into line pulses
// Ports: fclk, rst (async, active high); bus (line_trig_sequencer_if.slave) carrying enable, arm,
//   trig_toggle_in, dir_in, cfg_* in and line_trig_out, frame_active, frame_done, line_count,
//   overrun_cnt, state_o out.
// Optional: REVERSE_TRACK_EN enables backlash tracking on dir_in.
module line_trig_sequencer
  import line_trig_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PULSE_W = DEF_PULSE_W,
  parameter int MIN_GAP = DEF_MIN_GAP
) (
  input logic                  fclk,
  input logic                  rst,
  line_trig_sequencer_if.slave bus
);

  state_e           state_q, state_d;
  logic             tog_q;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] lc_q, lc_d;
  logic [7:0]       ovr_q, ovr_d;
  logic [CNT_W-1:0] sd_q, sd_d;
  logic [CNT_W-1:0] nl_q, nl_d;
  logic             cont_q, cont_d;

  logic evt, qual, frame_live, lines_reached, req;
  logic pg_accept, pg_drop, pg_rise, pg_pulse, pg_busy;
  logic unused_accept;

  assign evt           = bus.trig_toggle_in ^ tog_q;
  assign frame_live    = bus.enable && (state_q == ST_DELAY || state_q == ST_ACTIVE);
  assign lines_reached = (nl_q != '0) && (lc_q == nl_q);
  // Once the frame's lines are all issued, trailing events are neither lines nor overruns.
  assign req           = qual && bus.enable && (state_q == ST_ACTIVE) && !lines_reached;
  assign unused_accept = pg_accept;

`ifdef REVERSE_TRACK_EN
  logic [CNT_W-1:0] bl_q, bl_d;
  // Forward motion only counts again once it has undone all recorded reverse travel.
  assign qual = evt && bus.dir_in && (bl_q == '0);
`else
  logic unused_dir;
  assign unused_dir = bus.dir_in;
  assign qual       = evt;
`endif

  line_trig_pulse_gen #(
    .PULSE_W (PULSE_W),
    .MIN_GAP (MIN_GAP)
  ) u_pulse_gen (
    .clk      (fclk),
    .rst      (rst),
    .req_i    (req),
    .accept_o (pg_accept),
    .drop_o   (pg_drop),
    .rise_o   (pg_rise),
    .pulse_o  (pg_pulse),
    .busy_o   (pg_busy)
  );

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    lc_d    = lc_q;
    ovr_d   = ovr_q;
    sd_d    = sd_q;
    nl_d    = nl_q;
    cont_d  = cont_q;
`ifdef REVERSE_TRACK_EN
    bl_d    = bl_q;
    if (evt && frame_live) begin
      if (!bus.dir_in) begin
        if (bl_q != '1) bl_d = bl_q + CNT_W'(1);
      end else if (bl_q != '0) begin
        bl_d = bl_q - CNT_W'(1);
      end
    end
`endif
    if (pg_rise) lc_d = lc_q + CNT_W'(1);
    if (pg_drop && ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;

    case (state_q)
      ST_IDLE: begin
        if (bus.arm && bus.enable) begin
          state_d = ST_DELAY;
          dcnt_d  = '0;
          lc_d    = '0;
          ovr_d   = '0;
          sd_d    = bus.cfg_start_delay;
          nl_d    = bus.cfg_lines;
          cont_d  = bus.cfg_continuous;
`ifdef REVERSE_TRACK_EN
          bl_d    = '0;
`endif
        end
      end
      ST_DELAY: begin
        if (!bus.enable) begin
          if (!pg_busy) state_d = ST_IDLE;
        end else if (dcnt_q == sd_q) begin
          state_d = ST_ACTIVE;
        end else if (qual) begin
          dcnt_d = dcnt_q + CNT_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (!bus.enable) begin
          if (!pg_busy) state_d = ST_IDLE;
        end else if (lines_reached && !pg_busy) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (cont_q && bus.enable) begin
          state_d = ST_DELAY;
          dcnt_d  = '0;
          lc_d    = '0;
          sd_d    = bus.cfg_start_delay;
          nl_d    = bus.cfg_lines;
          cont_d  = bus.cfg_continuous;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tog_q   <= 1'b0;
      dcnt_q  <= '0;
      lc_q    <= '0;
      ovr_q   <= '0;
      sd_q    <= '0;
      nl_q    <= '0;
      cont_q  <= 1'b0;
`ifdef REVERSE_TRACK_EN
      bl_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      tog_q   <= bus.trig_toggle_in;
      dcnt_q  <= dcnt_d;
      lc_q    <= lc_d;
      ovr_q   <= ovr_d;
      sd_q    <= sd_d;
      nl_q    <= nl_d;
      cont_q  <= cont_d;
`ifdef REVERSE_TRACK_EN
      bl_q    <= bl_d;
`endif
    end
  end

  assign bus.line_trig_out = pg_pulse;
  assign bus.frame_active  = (state_q == ST_DELAY) || (state_q == ST_ACTIVE);
  assign bus.frame_done    = (state_q == ST_DONE);
  assign bus.line_count    = lc_q;
  assign bus.overrun_cnt   = ovr_q;
  assign bus.state_o       = state_q;

endmodule

// File: tb/tb_line_trig_sequencer.sv
// tb/tb_line_trig_sequencer.sv - self-checking bench for line_trig_sequencer
module tb_line_trig_sequencer;
  localparam int CNT_W = 16;
  localparam int PW    = 8;
  localparam int MG    = 64;
  localparam int P_IDLE = 0, P_DELAY = 1, P_ACTIVE = 2;

  logic fclk = 1'b0;
  logic rst  = 1'b0;

  line_trig_sequencer_if #(.CNT_W(CNT_W)) bus ();

  line_trig_sequencer #(.CNT_W(CNT_W), .PULSE_W(PW), .MIN_GAP(MG)) dut (
    .fclk (fclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 fclk = ~fclk;

  int cyc = 0;
  always @(posedge fclk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: rising-edge times (edge index) and widths of line_trig_out, frame_done cycles.
  int   dut_rise[$];
  int   dut_width[$];
  int   fd_seen = 0;
  int   wcur = 0;
  logic lt_prev = 1'b0;
  logic fd_prev = 1'b0;
  bit   lc_clear_chk = 1'b0;

  always @(negedge fclk) begin
    if (bus.line_trig_out && !lt_prev) begin
      dut_rise.push_back(cyc);
      wcur = 0;
    end
    if (bus.line_trig_out) wcur++;
    if (!bus.line_trig_out && lt_prev) dut_width.push_back(wcur);
    lt_prev = bus.line_trig_out;
    if (bus.frame_done) fd_seen++;
    if (lc_clear_chk && fd_prev) check_eq("line_count after frame_done", bus.line_count, 0);
    fd_prev = bus.frame_done;
  end

  // Reference model: frame-level bookkeeping per event, in edge-index time.
  int exp_rise[$];
  int m_phase = P_IDLE;
  int m_dcnt = 0, m_lines = 0, m_ovr = 0, m_bl = 0, m_fd = 0, m_last = -100000;
  int m_sd = 0, m_nl = 0;
  bit m_cont = 0;
  int cfg_sd = 0, cfg_nl = 0;
  bit cfg_cont = 0, en = 0;

  function automatic void m_load_cfg();
    m_sd = cfg_sd; m_nl = cfg_nl; m_cont = cfg_cont;
  endfunction

  // Frame ends once its last pulse is over: DONE one edge later, restart/idle the edge after.
  function automatic void m_resolve(input int now);
    if (m_phase == P_ACTIVE && m_nl != 0 && m_lines == m_nl && now >= m_last + PW + 2) begin
      m_fd++;
      if (m_cont && en) begin
        m_load_cfg();
        m_lines = 0; m_dcnt = 0;
        m_phase = (m_sd == 0) ? P_ACTIVE : P_DELAY;
      end else begin
        m_phase = P_IDLE;
      end
    end
  endfunction

  function automatic void m_event(input int k, input bit d);
    bit q;
    m_resolve(k - 1);
    if (m_phase == P_IDLE) return;
    q = 1'b1;
`ifdef REVERSE_TRACK_EN
    if (!d) begin
      if (m_bl < 65535) m_bl++;
      q = 1'b0;
    end else if (m_bl != 0) begin
      m_bl--;
      q = 1'b0;
    end
`endif
    if (m_phase == P_DELAY) begin
      if (q) begin
        m_dcnt++;
        if (m_dcnt == m_sd) m_phase = P_ACTIVE;
      end
    end else begin
      if (m_nl != 0 && m_lines == m_nl) return;
      if (q) begin
        if (k + 1 - m_last >= MG) begin
          exp_rise.push_back(k + 1);
          m_last  = k + 1;
          m_lines = (m_lines + 1) % 65536;
        end else if (m_ovr < 255) begin
          m_ovr++;
        end
      end
    end
  endfunction

  function automatic void m_arm(input int k);
    m_resolve(k - 1);
    if (m_phase == P_IDLE && en) begin
      m_load_cfg();
      m_lines = 0; m_ovr = 0; m_dcnt = 0; m_bl = 0;
      m_phase = (m_sd == 0) ? P_ACTIVE : P_DELAY;
    end
  endfunction

  task automatic gap(input int n);
    repeat (n) @(negedge fclk);
  endtask

  task automatic tog(input bit d);
    @(negedge fclk);
    bus.dir_in = d;
    bus.trig_toggle_in = ~bus.trig_toggle_in;
    m_event(cyc + 1, d);
  endtask

  task automatic do_arm();
    @(negedge fclk);
    bus.arm = 1'b1;
    m_arm(cyc + 1);
    @(negedge fclk);
    bus.arm = 1'b0;
  endtask

  task automatic set_en(input bit e);
    @(negedge fclk);
    en = e;
    bus.enable = e;
    if (!e) begin
      m_resolve(cyc);
      m_phase = P_IDLE;
    end
  endtask

  task automatic apply_cfg(input int sd, input int nl, input bit cont);
    @(negedge fclk);
    cfg_sd = sd; cfg_nl = nl; cfg_cont = cont;
    bus.cfg_start_delay = CNT_W'(sd);
    bus.cfg_lines       = CNT_W'(nl);
    bus.cfg_continuous  = cont;
  endtask

  task automatic cmp_pulses(input string tag);
    int n;
    gap(PW + 4);
    check_eq({tag, " pulse count"}, dut_rise.size(), exp_rise.size());
    n = (dut_rise.size() < exp_rise.size()) ? dut_rise.size() : exp_rise.size();
    for (int i = 0; i < n; i++)
      check_eq($sformatf("%s rise[%0d]", tag, i), dut_rise[i], exp_rise[i]);
    for (int i = 0; i < dut_width.size(); i++)
      check_eq($sformatf("%s width[%0d]", tag, i), dut_width[i], PW);
    dut_rise.delete(); dut_width.delete(); exp_rise.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    bus.enable = 0; bus.arm = 0; bus.trig_toggle_in = 0; bus.dir_in = 1;
    bus.cfg_start_delay = '0; bus.cfg_lines = '0; bus.cfg_continuous = 0;
    #2 rst = 1'b1;
    repeat (3) @(negedge fclk);
    check_eq("reset state_o", bus.state_o, 0);
    check_eq("reset line_trig_out", bus.line_trig_out, 0);
    check_eq("reset frame_active", bus.frame_active, 0);
    check_eq("reset frame_done", bus.frame_done, 0);
    check_eq("reset line_count", bus.line_count, 0);
    check_eq("reset overrun_cnt", bus.overrun_cnt, 0);
    rst = 1'b0;
    set_en(1);

    // Basic frame
    apply_cfg(3, 4, 0);
    do_arm();
    check_eq("basic state after arm", bus.state_o, 1);
    repeat (10) begin gap(199); tog(1); end
    gap(50);
    m_resolve(cyc);
    cmp_pulses("basic");
    check_eq("basic line_count", bus.line_count, m_lines);
    check_eq("basic frame_done count", fd_seen, m_fd);
    check_eq("basic final state", bus.state_o, 0);
    check_eq("basic overrun", bus.overrun_cnt, m_ovr);

    // Continuous frames with random spacing and direction
    apply_cfg(1, 2, 1);
    lc_clear_chk = 1'b1;
    do_arm();
    repeat (30) begin gap($urandom_range(19, 119)); tog(1'($urandom_range(0, 1))); end
    gap(40);
    m_resolve(cyc);
    cmp_pulses("cont");
    check_eq("cont frame_done count", fd_seen, m_fd);
    check_eq("cont overrun", bus.overrun_cnt, m_ovr);
    set_en(0);
    lc_clear_chk = 1'b0;
    gap(20);
    check_eq("cont stop state", bus.state_o, 0);
    check_eq("cont stop line_count", bus.line_count, m_lines);
    set_en(1);

    // Free-run frames, zero and random start delay
    for (int f = 0; f < 2; f++) begin
      apply_cfg((f == 0) ? 0 : $urandom_range(1, 4), 0, 0);
      do_arm();
      repeat (40) begin gap($urandom_range(19, 119)); tog(1); end
      cmp_pulses($sformatf("freerun%0d", f));
      check_eq($sformatf("freerun%0d overrun", f), bus.overrun_cnt, m_ovr);
      check_eq($sformatf("freerun%0d line_count", f), bus.line_count, m_lines);
      check_eq($sformatf("freerun%0d state", f), bus.state_o, m_phase);
      set_en(0); gap(20); set_en(1);
    end

    // Overrun saturation
    apply_cfg(0, 0, 0);
    do_arm();
    check_eq("overrun cleared by arm", bus.overrun_cnt, m_ovr);
    for (int i = 0; i < 600; i++) begin
      gap(29); tog(1);
      if (i == 9) begin gap(2); check_eq("overrun after 10 events", bus.overrun_cnt, m_ovr); end
    end
    cmp_pulses("overrun");
    check_eq("overrun saturated", bus.overrun_cnt, m_ovr);
    set_en(0); gap(20); set_en(1);

    // Abort 3 cycles into a pulse
    apply_cfg(0, 0, 0);
    do_arm();
    gap(10); tog(1);
    gap(3); set_en(0);
    fd0 = fd_seen;
    gap(12); tog(1); gap(50); tog(0); gap(20);
    cmp_pulses("abort");
    check_eq("abort no frame_done", fd_seen, fd0);
    check_eq("abort state", bus.state_o, 0);
    check_eq("abort frame_active", bus.frame_active, 0);
    set_en(1);

    // Asynchronous reset in the middle of a pulse
    apply_cfg(0, 0, 0);
    do_arm();
    gap(10); tog(1); gap(4);
    check_eq("pre-reset line_trig_out", bus.line_trig_out, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("async reset line_trig_out", bus.line_trig_out, 0);
    check_eq("async reset state_o", bus.state_o, 0);
    check_eq("async reset frame_active", bus.frame_active, 0);
    check_eq("async reset line_count", bus.line_count, 0);
    gap(2);
    bus.trig_toggle_in = 1'b0;
    @(negedge fclk);
    rst = 1'b0;
    m_phase = P_IDLE; m_lines = 0; m_ovr = 0; m_bl = 0; m_dcnt = 0; m_last = -100000;
    dut_rise.delete(); dut_width.delete(); exp_rise.delete();
    gap(3);
    check_eq("post-reset state", bus.state_o, 0);
    apply_cfg(0, 1, 0);
    do_arm();
    gap(30); tog(1); gap(50);
    m_resolve(cyc);
    cmp_pulses("post-reset");
    check_eq("post-reset frame_done count", fd_seen, m_fd);
    check_eq("post-reset line_count", bus.line_count, m_lines);

`ifdef REVERSE_TRACK_EN
    // Backlash: 3 reverse then 5 forward events
    apply_cfg(0, 0, 0);
    do_arm();
    repeat (3) begin gap(99); tog(0); end
    repeat (5) begin gap(99); tog(1); end
    gap(30);
    check_eq("reverse pulse count", dut_rise.size(), 2);
    cmp_pulses("reverse");
    set_en(0); gap(20);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
